traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
// Passive checker on the light outputs of the traffic-light controller (main/secondary/pedestrian).
// Decodes light patterns into phases, checks transition legality and phase durations against the
// controller timing parameters, and reports errors plus cycle statistics. Same clock domain, no outputs fed back.
// PARAMETERS
// FPGAFREQ       50_000_000  clk cycles per second
// T_GREENMAIN    18          expected main-green seconds
// T_YELLOWMAIN   4           expected main-yellow seconds
// T_GREENSEC     10          expected secondary-green seconds
// T_YELLOWSEC    3           expected secondary-yellow seconds
// T_GREENPEATON  5           expected pedestrian-green seconds
// T_REDPEATON    2           expected all-red seconds after pedestrian green
// T_RESET        3           expected all-red seconds after reset
// TOL_CYCLES     2           accepted +/- deviation in clk cycles per phase
// PORTS
// clk          in   1   clock
// reset        in   1   asynchronous, active-high reset
// main_lights  in   3   {red,yellow,green}
// sec_lights   in   3   {red,yellow,green}
// pea_lights   in   2   {red,green}
// phase        out  3   0 ALLRED,1 MG,2 MY,3 SG,4 SY,5 PG,7 ILLEGAL
// err_valid    out  1   one-cycle error pulse
// err_code     out  3   code of most recent error (held)
// err_sticky   out  1   set on any error, cleared only by reset
// cycle_count  out  8   completed main-green entries, wraps 255->0
// ped_count    out  8   pedestrian-green entries (see CONFIGURATION)
// BEHAVIOUR
// - Reset: phase=ALLRED, err_valid=0, err_code=0, err_sticky=0, counts=0, elapsed=0, first_red=1.
// - Inputs registered once; phase updates 1 cycle after the pattern changes on the inputs.
// - Decode (main,sec,pea): 100,100,10 ALLRED; 001,100,10 MG; 010,100,10 MY; 100,001,10 SG;
//   100,010,10 SY; 100,100,01 PG; any other pattern ILLEGAL.
// - Legal: ALLRED->MG, MG->MY, MY->SG, SG->SY, SY->MG, SY->PG, PG->ALLRED.
// - elapsed: DURW-bit cycle counter, DURW=$clog2((Tmax+1)*FPGAFREQ+TOL_CYCLES+1); cleared to 1 on
//   phase change, saturates at all-ones. Expected E = T*FPGAFREQ; ALLRED uses T_RESET when first_red=1,
//   else T_REDPEATON. first_red cleared on first exit from ALLRED.
// - On phase change out of a non-ILLEGAL phase: elapsed < E-TOL_CYCLES -> code 3 (SHORT).
// - While in a non-ILLEGAL phase: elapsed reaching E+TOL_CYCLES+1 -> code 4 (STUCK), once per phase;
//   no further long check at exit.
// - Entry into ILLEGAL -> code 1. Exit from ILLEGAL: no transition or duration check (resync).
// - Non-legal change between two decoded phases -> code 2.
// - Simultaneous conditions in one cycle: one pulse, priority 1 > 2 > 3.
// - err_valid asserted exactly 1 cycle with err_code updated the same cycle; err_sticky set same cycle.
// - cycle_count increments on every entry into MG (including ALLRED->MG after reset); 8-bit wrap.
// - Reset asserted mid-operation: all state returns to reset values immediately; no error reported.
// CONFIGURATION
// - TLM_PED_COUNT_EN defined: ped_count increments on every entry into PG, 8-bit wrap.
// - Not defined: ped_count tied to 8'd0; no counter logic synthesised; all else identical.
// TESTING (bench: FPGAFREQ=8, T_GREENMAIN=8, T_YELLOWMAIN=3, T_GREENSEC=6, T_YELLOWSEC=2,
//          T_GREENPEATON=5, T_REDPEATON=2, T_RESET=3, TOL_CYCLES=2)
// - Nominal: drive ALLRED 24, MG 64, MY 24, SG 48, SY 16, MG cycles -> err_sticky=0, cycle_count=2, phase tracks 1 cycle late.
// - Pedestrian: SY 16 -> PG 40 -> ALLRED 16 -> MG -> no error; ped_count=1 with macro, 0 without.
// - Short: MG held 60 cycles then MY -> err_valid pulse, err_code=3, err_sticky=1.
// - Stuck: MY held 30 cycles -> single pulse code 4 at elapsed 27, no pulse on later exit.
// - Illegal: main=011 for 1 cycle -> phase=7, code 1; next MG entry no code 2; MG->SG -> code 2.
// - Reset mid-MG at elapsed 30: all outputs 0/ALLRED next cycle; subsequent ALLRED uses T_RESET (24 ok).

Source files
------------

// File: rtl/traffic_light_monitor_if.sv
// Light inputs and checker results of traffic_light_monitor, grouped for connection.
// master drives the lights (controller side), slave is the monitor.
`timescale 1ns/1ps
interface traffic_light_monitor_if;
    logic [2:0] main_lights;
    logic [2:0] sec_lights;
    logic [1:0] pea_lights;
    logic [2:0] phase;
    logic       err_valid;
    logic [2:0] err_code;
    logic       err_sticky;
    logic [7:0] cycle_count;
    logic [7:0] ped_count;

    modport master (
        output main_lights, sec_lights, pea_lights,
        input  phase, err_valid, err_code, err_sticky, cycle_count, ped_count
    );
    modport slave (
        input  main_lights, sec_lights, pea_lights,
        output phase, err_valid, err_code, err_sticky, cycle_count, ped_count
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker: decodes light patterns into phases, checks transitions and phase durations.
// Optional macro TLM_PED_COUNT_EN enables the pedestrian-green entry counter.
`timescale 1ns/1ps
module traffic_light_monitor #(
    parameter int unsigned FPGAFREQ      = 50_000_000,
    parameter int unsigned T_GREENMAIN   = 18,
    parameter int unsigned T_YELLOWMAIN  = 4,
    parameter int unsigned T_GREENSEC    = 10,
    parameter int unsigned T_YELLOWSEC   = 3,
    parameter int unsigned T_GREENPEATON = 5,
    parameter int unsigned T_REDPEATON   = 2,
    parameter int unsigned T_RESET       = 3,
    parameter int unsigned TOL_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    traffic_light_monitor_if.slave mon
);
    typedef enum logic [2:0] {
        ALLRED  = 3'd0,
        MG      = 3'd1,
        MY      = 3'd2,
        SG      = 3'd3,
        SY      = 3'd4,
        PG      = 3'd5,
        ILLEGAL = 3'd7
    } phase_e;

    function automatic int unsigned max2(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_MAX = max2(max2(max2(T_GREENMAIN, T_YELLOWMAIN), max2(T_GREENSEC, T_YELLOWSEC)),
                                         max2(max2(T_GREENPEATON, T_REDPEATON), T_RESET));
    localparam int unsigned DURW  = $clog2((T_MAX + 1) * FPGAFREQ + TOL_CYCLES + 1);

    typedef logic [DURW-1:0] dur_t;
    typedef logic [DURW:0]   dur_wide_t;

    function automatic phase_e decode(logic [2:0] m, logic [2:0] s, logic [1:0] p);
        case ({m, s, p})
            8'b100_100_10: return ALLRED;
            8'b001_100_10: return MG;
            8'b010_100_10: return MY;
            8'b100_001_10: return SG;
            8'b100_010_10: return SY;
            8'b100_100_01: return PG;
            default:       return ILLEGAL;
        endcase
    endfunction

    function automatic logic legal(phase_e from, phase_e to);
        return (from == ALLRED && to == MG) || (from == MG && to == MY) ||
               (from == MY && to == SG)     || (from == SG && to == SY) ||
               (from == SY && to == MG)     || (from == SY && to == PG) ||
               (from == PG && to == ALLRED);
    endfunction

    function automatic dur_wide_t expected(phase_e ph, logic first_red);
        int unsigned secs;
        case (ph)
            ALLRED:  secs = first_red ? T_RESET : T_REDPEATON;
            MG:      secs = T_GREENMAIN;
            MY:      secs = T_YELLOWMAIN;
            SG:      secs = T_GREENSEC;
            SY:      secs = T_YELLOWSEC;
            PG:      secs = T_GREENPEATON;
            default: secs = 0;
        endcase
        return dur_wide_t'(secs * FPGAFREQ);
    endfunction

    phase_e     phase_q, phase_d, cur_phase;
    dur_t       elapsed_q, elapsed_d;
    logic       first_red_q, first_red_d;
    logic       err_valid_q, err_valid_d;
    logic [2:0] err_code_q, err_code_d;
    logic       err_sticky_q, err_sticky_d;
    logic [7:0] cycle_count_q, cycle_count_d;
    logic       changed;
    logic [2:0] code;
    dur_wide_t  exp_cur;
`ifdef TLM_PED_COUNT_EN
    logic [7:0] ped_count_q, ped_count_d;
`endif

    // Raw lights are decoded and compared against the held phase in the same cycle,
    // so phase and any error pulse appear together one clock after the light change.
    always_comb begin
        cur_phase     = decode(mon.main_lights, mon.sec_lights, mon.pea_lights);
        changed       = (cur_phase != phase_q);
        exp_cur       = expected(phase_q, first_red_q);
        phase_d       = cur_phase;
        elapsed_d     = changed ? dur_t'(1) : ((elapsed_q == '1) ? elapsed_q : elapsed_q + dur_t'(1));
        first_red_d   = first_red_q & ~(changed & (phase_q == ALLRED));
        cycle_count_d = cycle_count_q + ((changed && cur_phase == MG) ? 8'd1 : 8'd0);
        code          = 3'd0;
        if (changed) begin
            if (cur_phase == ILLEGAL) begin
                code = 3'd1;
            end else if (phase_q != ILLEGAL) begin
                if (!legal(phase_q, cur_phase))
                    code = 3'd2;
                else if ((dur_wide_t'(elapsed_q) + dur_wide_t'(TOL_CYCLES)) < exp_cur)
                    code = 3'd3;
            end
        end else if (phase_q != ILLEGAL &&
                     dur_wide_t'(elapsed_d) == exp_cur + dur_wide_t'(TOL_CYCLES + 1)) begin
            code = 3'd4;
        end
        err_valid_d  = (code != 3'd0);
        err_code_d   = err_valid_d ? code : err_code_q;
        err_sticky_d = err_sticky_q | err_valid_d;
`ifdef TLM_PED_COUNT_EN
        ped_count_d  = ped_count_q + ((changed && cur_phase == PG) ? 8'd1 : 8'd0);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= ALLRED;
            elapsed_q     <= '0;
            first_red_q   <= 1'b1;
            err_valid_q   <= 1'b0;
            err_code_q    <= '0;
            err_sticky_q  <= 1'b0;
            cycle_count_q <= '0;
`ifdef TLM_PED_COUNT_EN
            ped_count_q   <= '0;
`endif
        end else begin
            phase_q       <= phase_d;
            elapsed_q     <= elapsed_d;
            first_red_q   <= first_red_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
            err_sticky_q  <= err_sticky_d;
            cycle_count_q <= cycle_count_d;
`ifdef TLM_PED_COUNT_EN
            ped_count_q   <= ped_count_d;
`endif
        end
    end

    assign mon.phase       = phase_q;
    assign mon.err_valid   = err_valid_q;
    assign mon.err_code    = err_code_q;
    assign mon.err_sticky  = err_sticky_q;
    assign mon.cycle_count = cycle_count_q;
`ifdef TLM_PED_COUNT_EN
    assign mon.ped_count   = ped_count_q;
`else
    assign mon.ped_count   = '0;
`endif
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: decode table, hand sequences, random walk vs model.
`timescale 1ns/1ps
module tb_traffic_light_monitor;
    localparam int F = 8, TGM = 8, TYM = 3, TGS = 6, TYS = 2, TGP = 5, TRP = 2, TR = 3, TOL = 2;
`ifdef TLM_PED_COUNT_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif
    localparam logic [7:0] P_AR = 8'b100_100_10, P_MG = 8'b001_100_10, P_MY = 8'b010_100_10,
                           P_SG = 8'b100_001_10, P_SY = 8'b100_010_10, P_PG = 8'b100_100_01;

    typedef struct {
        logic [7:0] pat;
        int         exp_phase;
        int         exp_valid;
        int         exp_code;
    } dec_vec_t;
    dec_vec_t dec_tab[9];

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    traffic_light_monitor_if bus();
    traffic_light_monitor #(
        .FPGAFREQ(F), .T_GREENMAIN(TGM), .T_YELLOWMAIN(TYM), .T_GREENSEC(TGS), .T_YELLOWSEC(TYS),
        .T_GREENPEATON(TGP), .T_REDPEATON(TRP), .T_RESET(TR), .TOL_CYCLES(TOL)
    ) dut (
        .clk(clk), .reset(reset), .mon(bus)
    );

    int n_vec = 0, n_bad = 0;

    // Reference model: phase history since reset, durations taken as run lengths.
    int hist[$];
    int m_phase, m_code, m_cc, m_pc;
    bit m_valid, m_sticky, m_first_red;

    function automatic int exp_cycles(int ph, bit fr);
        int secs;
        case (ph)
            0: secs = fr ? TR : TRP;
            1: secs = TGM;
            2: secs = TYM;
            3: secs = TGS;
            4: secs = TYS;
            5: secs = TGP;
            default: secs = 0;
        endcase
        return secs * F;
    endfunction

    function automatic int decode(logic [7:0] p);
        if (p == P_AR) return 0;
        if (p == P_MG) return 1;
        if (p == P_MY) return 2;
        if (p == P_SG) return 3;
        if (p == P_SY) return 4;
        if (p == P_PG) return 5;
        return 7;
    endfunction

    function automatic logic [7:0] pat_of(int ph);
        logic [7:0] t[6];
        t = '{P_AR, P_MG, P_MY, P_SG, P_SY, P_PG};
        return t[ph];
    endfunction

    function automatic bit legal(int a, int b);
        return (a == 0 && b == 1) || (a == 1 && b == 2) || (a == 2 && b == 3) ||
               (a == 3 && b == 4) || (a == 4 && (b == 1 || b == 5)) || (a == 5 && b == 0);
    endfunction

    function automatic int trailing();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size() - 1]) n++;
            else break;
        end
        return (n > 127) ? 127 : n;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_phase = 0; m_code = 0; m_cc = 0; m_pc = 0;
        m_valid = 1'b0; m_sticky = 1'b0; m_first_red = 1'b1;
    endtask

    task automatic model_step(logic [7:0] p);
        int cur, prev_len, cur_len, e, code;
        cur      = decode(p);
        prev_len = trailing();
        e        = exp_cycles(m_phase, m_first_red);
        hist.push_back(cur);
        if (hist.size() > 256) void'(hist.pop_front());
        cur_len  = trailing();
        code     = 0;
        if (cur != m_phase) begin
            if (cur == 7) code = 1;
            else if (m_phase != 7) begin
                if (!legal(m_phase, cur)) code = 2;
                else if (prev_len + TOL < e) code = 3;
            end
            if (m_phase == 0) m_first_red = 1'b0;
            if (cur == 1) m_cc = (m_cc + 1) % 256;
            if (cur == 5 && PED_EN) m_pc = (m_pc + 1) % 256;
        end else if (m_phase != 7 && cur_len == e + TOL + 1) begin
            code = 4;
        end
        m_valid = (code != 0);
        if (m_valid) begin
            m_code   = code;
            m_sticky = 1'b1;
        end
        m_phase = cur;
    endtask

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(logic [7:0] p);
        {bus.main_lights, bus.sec_lights, bus.pea_lights} = p;
        @(posedge clk);
        #1;
        model_step(p);
        chk("phase", int'(bus.phase), m_phase);
        chk("err_valid", int'(bus.err_valid), int'(m_valid));
        chk("err_code", int'(bus.err_code), m_code);
        chk("err_sticky", int'(bus.err_sticky), int'(m_sticky));
        chk("cycle_count", int'(bus.cycle_count), m_cc);
        chk("ped_count", int'(bus.ped_count), m_pc);
    endtask

    task automatic run(logic [7:0] p, int n);
        for (int i = 0; i < n; i++) step(p);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_phase"}, int'(bus.phase), 0);
        chk({tag, "_valid"}, int'(bus.err_valid), 0);
        chk({tag, "_code"}, int'(bus.err_code), 0);
        chk({tag, "_sticky"}, int'(bus.err_sticky), 0);
        chk({tag, "_cc"}, int'(bus.cycle_count), 0);
        chk({tag, "_pc"}, int'(bus.ped_count), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {bus.main_lights, bus.sec_lights, bus.pea_lights} = P_AR;
        @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, at, code_seen, ph, dur, r;
        logic [7:0] g;

        dec_tab[0] = '{P_AR, 0, 0, 0};
        dec_tab[1] = '{P_MG, 1, 1, 3};
        dec_tab[2] = '{P_MY, 2, 1, 2};
        dec_tab[3] = '{P_SG, 3, 1, 2};
        dec_tab[4] = '{P_SY, 4, 1, 2};
        dec_tab[5] = '{P_PG, 5, 1, 2};
        dec_tab[6] = '{8'b000_100_10, 7, 1, 1};
        dec_tab[7] = '{8'b100_100_11, 7, 1, 1};
        dec_tab[8] = '{8'b001_001_10, 7, 1, 1};
        model_reset();
        {bus.main_lights, bus.sec_lights, bus.pea_lights} = P_AR;
        #12;

        for (int i = 0; i < 9; i++) begin
            do_reset();
            step(dec_tab[i].pat);
            chk("decode_phase", int'(bus.phase), dec_tab[i].exp_phase);
            chk("decode_valid", int'(bus.err_valid), dec_tab[i].exp_valid);
            chk("decode_code", int'(bus.err_code), dec_tab[i].exp_code);
        end

        // Nominal cycle then pedestrian branch.
        do_reset();
        run(P_AR, 24);
        chk("nom_phase_late", int'(bus.phase), 0);
        step(P_MG);
        chk("nom_phase_mg", int'(bus.phase), 1);
        run(P_MG, 63); run(P_MY, 24); run(P_SG, 48); run(P_SY, 16);
        run(P_MG, 64); step(P_MY);
        chk("nom_sticky", int'(bus.err_sticky), 0);
        chk("nom_cycle_count", int'(bus.cycle_count), 2);
        run(P_MY, 23); run(P_SG, 48); run(P_SY, 16); run(P_PG, 40); run(P_AR, 16); step(P_MG);
        chk("ped_sticky", int'(bus.err_sticky), 0);
        chk("ped_count", int'(bus.ped_count), PED_EN ? 1 : 0);

        // Short main green.
        run(P_MG, 59);
        step(P_MY);
        chk("short_valid", int'(bus.err_valid), 1);
        chk("short_code", int'(bus.err_code), 3);
        chk("short_sticky", int'(bus.err_sticky), 1);

        // Stuck main yellow.
        pulses = 0; at = 0; code_seen = 0;
        for (int i = 2; i <= 30; i++) begin
            step(P_MY);
            if (bus.err_valid) begin
                pulses++;
                at = i;
                code_seen = int'(bus.err_code);
            end
        end
        chk("stuck_pulses", pulses, 1);
        chk("stuck_at", at, 27);
        chk("stuck_code", code_seen, 4);
        step(P_SG);
        chk("stuck_exit_quiet", int'(bus.err_valid), 0);

        // Illegal pattern, resync, then illegal transition.
        step(8'b011_100_10);
        chk("illegal_phase", int'(bus.phase), 7);
        chk("illegal_valid", int'(bus.err_valid), 1);
        chk("illegal_code", int'(bus.err_code), 1);
        step(P_MG);
        chk("resync_phase", int'(bus.phase), 1);
        chk("resync_quiet", int'(bus.err_valid), 0);
        step(P_SG);
        chk("badtrans_valid", int'(bus.err_valid), 1);
        chk("badtrans_code", int'(bus.err_code), 2);

        // Asynchronous reset mid main green.
        do_reset();
        run(P_AR, 24); run(P_MG, 30);
        #1 reset = 1'b1;
        #1 chk_zero("midreset");
        {bus.main_lights, bus.sec_lights, bus.pea_lights} = P_AR;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(P_AR, 24);
        step(P_MG);
        chk("post_reset_quiet", int'(bus.err_valid), 0);

        // Boundaries of the post-reset all-red.
        do_reset();
        run(P_AR, 21); step(P_MG);
        chk("ar21_short_code", int'(bus.err_code), 3);
        do_reset();
        run(P_AR, 22); step(P_MG);
        chk("ar22_quiet", int'(bus.err_valid), 0);

        // Random walk around nominal timings.
        do_reset();
        ph = 0;
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                do_reset();
                ph = 0;
            end else if (r < 10) begin
                g = 8'($urandom);
                run(g, $urandom_range(1, 3));
            end else begin
                if (r < 15) ph = $urandom_range(0, 5);
                else case (ph)
                    0: ph = 1;
                    1: ph = 2;
                    2: ph = 3;
                    3: ph = 4;
                    4: ph = $urandom_range(0, 1) ? 1 : 5;
                    default: ph = 0;
                endcase
                dur = exp_cycles(ph, m_first_red) - 4 + $urandom_range(0, 10);
                if (dur < 1) dur = 1;
                run(pat_of(ph), dur);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
